// File: rtl/blend_pipe_if.sv
// blend_pipe_if: pixel-in / pixel-out stream bundle for blend_pipe.
// slave  = blender view (consumes i_*, drives o_*); master = producer/consumer view.
interface blend_pipe_if #(
    parameter int unsigned BG_W  = 5,
    parameter int unsigned PX_W  = 8,
    parameter int unsigned TAG_W = 20
);
    // Upstream handshake and pixel
    logic             i_valid;
    logic             o_ready;
    logic [BG_W-1:0]  i_bg_r;
    logic [BG_W-1:0]  i_bg_g;
    logic [BG_W-1:0]  i_bg_b;
    logic             i_bg_mask;
    logic [PX_W-1:0]  i_px_r;
    logic [PX_W-1:0]  i_px_g;
    logic [PX_W-1:0]  i_px_b;
    logic             i_px_stp;
    logic             i_px_transp;
    logic             i_semi_en;
    logic [1:0]       i_mode;
    logic             i_check_mask;
    logic             i_set_mask;
    logic             i_dither_en;
    logic [1:0]       i_x2;
    logic [1:0]       i_y2;
    logic [TAG_W-1:0] i_tag;

    // Downstream handshake and result
    logic             o_valid;
    logic             i_ready;
    logic [PX_W-1:0]  o_r;
    logic [PX_W-1:0]  o_g;
    logic [PX_W-1:0]  o_b;
    logic             o_mask;
    logic             o_we;
    logic [TAG_W-1:0] o_tag;

    modport slave (
        input  i_valid, i_bg_r, i_bg_g, i_bg_b, i_bg_mask, i_px_r, i_px_g, i_px_b,
               i_px_stp, i_px_transp, i_semi_en, i_mode, i_check_mask, i_set_mask,
               i_dither_en, i_x2, i_y2, i_tag, i_ready,
        output o_ready, o_valid, o_r, o_g, o_b, o_mask, o_we, o_tag
    );

    modport master (
        output i_valid, i_bg_r, i_bg_g, i_bg_b, i_bg_mask, i_px_r, i_px_g, i_px_b,
               i_px_stp, i_px_transp, i_semi_en, i_mode, i_check_mask, i_set_mask,
               i_dither_en, i_x2, i_y2, i_tag, i_ready,
        input  o_ready, o_valid, o_r, o_g, o_b, o_mask, o_we, o_tag
    );
endinterface

// File: rtl/blend_pipe.sv
// blend_pipe: two-stage PSX semi-transparency blender with valid/ready and global stall.
// S1 decodes blend/skip, expands the background and picks the F operand; S2 adds, dithers,
// clamps and holds the registered outputs.
// Optional feature: define BLEND_DITHER_EN to build the 4x4 ordered-dither offset.
module blend_pipe #(
    parameter int unsigned BG_W  = 5,
    parameter int unsigned PX_W  = 8,
    parameter int unsigned TAG_W = 20
) (
    input  logic        i_clk,
    input  logic        i_rst,
    blend_pipe_if.slave bus
);
    localparam int unsigned REP_W = PX_W - BG_W;
    localparam int unsigned DP_W  = PX_W + 3;

    // Stage 1 state
    logic                       r_s1_valid;
    logic [2:0][PX_W-1:0]       r_s1_bx;
    logic [2:0][PX_W-1:0]       r_s1_f;
    logic                       r_s1_blend;
    logic [1:0]                 r_s1_mode;
    logic                       r_s1_we;
    logic                       r_s1_mask;
    logic [TAG_W-1:0]           r_s1_tag;
`ifdef BLEND_DITHER_EN
    logic signed [3:0]          r_s1_dith;
    logic signed [3:0]          w_dith;
`else
    logic                       w_unused;
`endif

    // Stage 2 (output) state
    logic                       r_s2_valid;
    logic [2:0][PX_W-1:0]       r_s2_rgb;
    logic                       r_s2_mask;
    logic                       r_s2_we;
    logic [TAG_W-1:0]           r_s2_tag;

    logic                       w_stall;
    logic                       w_blend;
    logic [2:0][BG_W-1:0]       w_bg;
    logic [2:0][PX_W-1:0]       w_px;
    logic [2:0][PX_W-1:0]       w_bx;
    logic [2:0][PX_W-1:0]       w_fop;
    logic [2:0][PX_W-1:0]       w_res;

    // Whole pipe freezes while the output is offered but not taken
    assign w_stall     = r_s2_valid & ~bus.i_ready;
    assign bus.o_ready = ~w_stall;

    assign w_blend = bus.i_px_stp ? (~bus.i_px_transp & bus.i_semi_en) : bus.i_px_transp;

    // S1 decode: background bit-replication and mode-3 quarter of F
    always_comb begin
        w_bg[0] = bus.i_bg_r;
        w_bg[1] = bus.i_bg_g;
        w_bg[2] = bus.i_bg_b;
        w_px[0] = bus.i_px_r;
        w_px[1] = bus.i_px_g;
        w_px[2] = bus.i_px_b;
        for (int c = 0; c < 3; c++) begin
            w_bx[c]  = {w_bg[c], w_bg[c][BG_W-1 -: REP_W]};
            w_fop[c] = (w_blend && bus.i_mode == 2'd3) ? (w_px[c] >> 2) : w_px[c];
        end
    end

`ifdef BLEND_DITHER_EN
    // PSX 4x4 dither offset, rows by y, columns by x
    always_comb begin
        w_dith = 4'sd0;
        if (bus.i_dither_en) begin
            case ({bus.i_y2, bus.i_x2})
                4'h0: w_dith = -4'sd4;
                4'h1: w_dith =  4'sd0;
                4'h2: w_dith = -4'sd3;
                4'h3: w_dith =  4'sd1;
                4'h4: w_dith =  4'sd2;
                4'h5: w_dith = -4'sd2;
                4'h6: w_dith =  4'sd3;
                4'h7: w_dith = -4'sd1;
                4'h8: w_dith = -4'sd3;
                4'h9: w_dith =  4'sd1;
                4'hA: w_dith = -4'sd4;
                4'hB: w_dith =  4'sd0;
                4'hC: w_dith =  4'sd3;
                4'hD: w_dith = -4'sd1;
                4'hE: w_dith =  4'sd2;
                default: w_dith = -4'sd2;
            endcase
        end
    end
`else
    assign w_unused = ^{bus.i_dither_en, bus.i_x2, bus.i_y2};
`endif

    // S2 arithmetic: signed add/sub with headroom, then clamp to [0, 2^PX_W-1]
    always_comb begin
        logic signed [DP_W-1:0] v_b;
        logic signed [DP_W-1:0] v_f;
        logic signed [DP_W-1:0] v_sum;
        v_b   = '0;
        v_f   = '0;
        v_sum = '0;
        w_res = '0;
        for (int c = 0; c < 3; c++) begin
            v_b = $signed({3'b000, r_s1_bx[c]});
            v_f = $signed({3'b000, r_s1_f[c]});
            if (!r_s1_blend) begin
                v_sum = v_f;
            end else begin
                case (r_s1_mode)
                    2'd0:    v_sum = (v_b + v_f) >>> 1;
                    2'd2:    v_sum = v_b - v_f;
                    default: v_sum = v_b + v_f;  // modes 1 and 3 (F already quartered)
                endcase
            end
`ifdef BLEND_DITHER_EN
            v_sum = v_sum + {{(DP_W-4){r_s1_dith[3]}}, r_s1_dith};
`endif
            if (v_sum[DP_W-1]) begin
                w_res[c] = '0;
            end else if (|v_sum[DP_W-2:PX_W]) begin
                w_res[c] = '1;
            end else begin
                w_res[c] = v_sum[PX_W-1:0];
            end
        end
    end

    // S1 register: capture input and decoded operands when the pipe moves
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_bx    <= '0;
            r_s1_f     <= '0;
            r_s1_blend <= 1'b0;
            r_s1_mode  <= 2'd0;
            r_s1_we    <= 1'b0;
            r_s1_mask  <= 1'b0;
            r_s1_tag   <= '0;
`ifdef BLEND_DITHER_EN
            r_s1_dith  <= 4'sd0;
`endif
        end else if (!w_stall) begin
            r_s1_valid <= bus.i_valid;
            r_s1_bx    <= w_bx;
            r_s1_f     <= w_fop;
            r_s1_blend <= w_blend;
            r_s1_mode  <= bus.i_mode;
            r_s1_we    <= ~(bus.i_check_mask & bus.i_bg_mask);
            r_s1_mask  <= bus.i_set_mask | bus.i_px_stp;
            r_s1_tag   <= bus.i_tag;
`ifdef BLEND_DITHER_EN
            r_s1_dith  <= w_dith;
`endif
        end
    end

    // S2 register: registered outputs, held while stalled
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_valid <= 1'b0;
            r_s2_rgb   <= '0;
            r_s2_mask  <= 1'b0;
            r_s2_we    <= 1'b0;
            r_s2_tag   <= '0;
        end else if (!w_stall) begin
            r_s2_valid <= r_s1_valid;
            r_s2_rgb   <= w_res;
            r_s2_mask  <= r_s1_mask;
            r_s2_we    <= r_s1_we;
            r_s2_tag   <= r_s1_tag;
        end
    end

    assign bus.o_valid = r_s2_valid;
    assign bus.o_r     = r_s2_rgb[0];
    assign bus.o_g     = r_s2_rgb[1];
    assign bus.o_b     = r_s2_rgb[2];
    assign bus.o_mask  = r_s2_mask;
    assign bus.o_we    = r_s2_we;
    assign bus.o_tag   = r_s2_tag;
endmodule

// File: tb/tb_blend_pipe.sv
// tb_blend_pipe: directed vector table for blend_pipe plus stall, gap and reset sequences.
module tb_blend_pipe;
    localparam int unsigned BG_W  = 5;
    localparam int unsigned PX_W  = 8;
    localparam int unsigned TAG_W = 20;
`ifdef BLEND_DITHER_EN
    localparam bit DITH = 1'b1;
`else
    localparam bit DITH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    blend_pipe_if #(.BG_W(BG_W), .PX_W(PX_W), .TAG_W(TAG_W)) bus ();

    blend_pipe #(.BG_W(BG_W), .PX_W(PX_W), .TAG_W(TAG_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0] mode;
        logic       stp;
        logic       transp;
        logic       semi;
        logic       chk;
        logic       bg_mask;
        logic       setm;
        logic       dith;
        logic [1:0] x2;
        logic [1:0] y2;
        logic [4:0] bg_r;
        logic [4:0] bg_g;
        logic [4:0] bg_b;
        logic [7:0] px_r;
        logic [7:0] px_g;
        logic [7:0] px_b;
        logic [7:0] e_r;
        logic [7:0] e_g;
        logic [7:0] e_b;
        logic       e_mask;
        logic       e_we;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_valid      = 1'b0;
        bus.i_bg_r       = '0;
        bus.i_bg_g       = '0;
        bus.i_bg_b       = '0;
        bus.i_bg_mask    = 1'b0;
        bus.i_px_r       = '0;
        bus.i_px_g       = '0;
        bus.i_px_b       = '0;
        bus.i_px_stp     = 1'b0;
        bus.i_px_transp  = 1'b0;
        bus.i_semi_en    = 1'b0;
        bus.i_mode       = 2'd0;
        bus.i_check_mask = 1'b0;
        bus.i_set_mask   = 1'b0;
        bus.i_dither_en  = 1'b0;
        bus.i_x2         = 2'd0;
        bus.i_y2         = 2'd0;
        bus.i_tag        = '0;
    endtask

    // Stream pixel k: no blend, so the output must equal F exactly
    task automatic load_px(input int k);
        bus.i_bg_r  = 5'd31;
        bus.i_bg_g  = 5'd31;
        bus.i_bg_b  = 5'd31;
        bus.i_px_r  = 8'(k * 10);
        bus.i_px_g  = 8'(255 - k);
        bus.i_px_b  = 8'(k);
        bus.i_tag   = 20'(k);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        logic [19:0] tag;
        v   = vecs[i];
        tag = 20'h5A000 + 20'(i);
        @(negedge clk);
        bus.i_mode       = v.mode;
        bus.i_px_stp     = v.stp;
        bus.i_px_transp  = v.transp;
        bus.i_semi_en    = v.semi;
        bus.i_check_mask = v.chk;
        bus.i_bg_mask    = v.bg_mask;
        bus.i_set_mask   = v.setm;
        bus.i_dither_en  = v.dith;
        bus.i_x2         = v.x2;
        bus.i_y2         = v.y2;
        bus.i_bg_r       = v.bg_r;
        bus.i_bg_g       = v.bg_g;
        bus.i_bg_b       = v.bg_b;
        bus.i_px_r       = v.px_r;
        bus.i_px_g       = v.px_g;
        bus.i_px_b       = v.px_b;
        bus.i_tag        = tag;
        bus.i_valid      = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        check($sformatf("v%0d_early_valid", i), 32'(bus.o_valid), 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_valid", i), 32'(bus.o_valid), 32'd1);
        check($sformatf("v%0d_r", i), 32'(bus.o_r), 32'(v.e_r));
        check($sformatf("v%0d_g", i), 32'(bus.o_g), 32'(v.e_g));
        check($sformatf("v%0d_b", i), 32'(bus.o_b), 32'(v.e_b));
        check($sformatf("v%0d_mask", i), 32'(bus.o_mask), 32'(v.e_mask));
        check($sformatf("v%0d_we", i), 32'(bus.o_we), 32'(v.e_we));
        check($sformatf("v%0d_tag", i), 32'(bus.o_tag), 32'(tag));
    endtask

    // 16 pixels with i_ready low in cycles 3..7
    task automatic run_stream();
        int          sent;
        int          got;
        logic        stall;
        logic        prev_stall;
        logic        acc;
        logic [7:0]  pr;
        logic [19:0] ptag;
        sent       = 0;
        got        = 0;
        prev_stall = 1'b0;
        pr         = '0;
        ptag       = '0;
        @(negedge clk);
        idle_inputs();
        load_px(0);
        bus.i_valid = 1'b1;
        for (int c = 0; c < 80 && got < 16; c++) begin
            bus.i_ready = !(c >= 3 && c <= 7);
            #1;
            stall = bus.o_valid && !bus.i_ready;
            check("str_o_ready", 32'(bus.o_ready), 32'(!stall));
            if (prev_stall) begin
                check("str_hold_valid", 32'(bus.o_valid), 32'd1);
                check("str_hold_r", 32'(bus.o_r), 32'(pr));
                check("str_hold_tag", 32'(bus.o_tag), 32'(ptag));
            end
            if (bus.o_valid && bus.i_ready) begin
                check("str_tag", 32'(bus.o_tag), 32'(got));
                check("str_r", 32'(bus.o_r), 32'(got * 10));
                check("str_g", 32'(bus.o_g), 32'(255 - got));
                check("str_b", 32'(bus.o_b), 32'(got));
                got++;
            end
            acc        = bus.i_valid && bus.o_ready;
            pr         = bus.o_r;
            ptag       = bus.o_tag;
            prev_stall = stall;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                if (sent < 16) load_px(sent);
                else bus.i_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("str_delivered", 32'(got), 32'd16);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // mode stp tr semi chk bgm set dith x2 y2 | bg r g b | px r g b | exp r g b mask we
        vecs[0]  = '{2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                     5'd16, 5'd31, 5'd0, 8'd100, 8'd0, 8'd255, 8'd116, 8'd127, 8'd127,
                     1'b1, 1'b1};
        vecs[1]  = '{2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                     5'd1, 5'd31, 5'd16, 8'd200, 8'd55, 8'd132, 8'd0, 8'd200, 8'd0,
                     1'b1, 1'b1};
        vecs[2]  = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0,
                     5'd31, 5'd16, 5'd0, 8'd255, 8'd100, 8'd7, 8'd255, 8'd232, 8'd7,
                     1'b1, 1'b1};
        vecs[3]  = '{2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                     5'd16, 5'd31, 5'd1, 8'd103, 8'd255, 8'd3, 8'd157, 8'd255, 8'd8,
                     1'b1, 1'b1};
        vecs[4]  = '{2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                     5'd31, 5'd31, 5'd31, 8'd12, 8'd34, 8'd56, 8'd12, 8'd34, 8'd56,
                     1'b0, 1'b1};
        vecs[5]  = '{2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                     5'd31, 5'd31, 5'd31, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3,
                     1'b1, 1'b1};
        vecs[6]  = '{2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                     5'd0, 5'd0, 5'd0, 8'd200, 8'd201, 8'd202, 8'd200, 8'd201, 8'd202,
                     1'b1, 1'b1};
        vecs[7]  = '{2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0,
                     5'd16, 5'd16, 5'd16, 8'd100, 8'd100, 8'd100, 8'd116, 8'd116, 8'd116,
                     1'b1, 1'b0};
        vecs[8]  = '{2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                     5'd16, 5'd16, 5'd16, 8'd100, 8'd100, 8'd100, 8'd116, 8'd116, 8'd116,
                     1'b1, 1'b1};
        vecs[9]  = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0,
                     5'd16, 5'd16, 5'd16, 8'd100, 8'd100, 8'd100, 8'd116, 8'd116, 8'd116,
                     1'b0, 1'b1};
        vecs[10] = '{2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0,
                     5'd31, 5'd16, 5'd0, 8'd55, 8'd132, 8'd1, 8'd200, 8'd0, 8'd0,
                     1'b1, 1'b0};
        vecs[11] = '{2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0,
                     5'd0, 5'd0, 5'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                     1'b1, 1'b1};
        vecs[12] = '{2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1,
                     5'd0, 5'd0, 5'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                     1'b1, 1'b1};
        vecs[13] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1,
                     5'd0, 5'd0, 5'd0, 8'd100, 8'd100, 8'd100,
                     DITH ? 8'd103 : 8'd100, DITH ? 8'd103 : 8'd100, DITH ? 8'd103 : 8'd100,
                     1'b0, 1'b1};
        vecs[14] = '{2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd3,
                     5'd16, 5'd16, 5'd16, 8'd100, 8'd100, 8'd100,
                     DITH ? 8'd230 : 8'd232, DITH ? 8'd230 : 8'd232, DITH ? 8'd230 : 8'd232,
                     1'b1, 1'b1};
        vecs[15] = '{2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd3,
                     5'd16, 5'd16, 5'd16, 8'd100, 8'd100, 8'd100, 8'd232, 8'd232, 8'd232,
                     1'b1, 1'b1};

        idle_inputs();
        bus.i_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_r", 32'(bus.o_r), 32'd0);
        check("rst_g", 32'(bus.o_g), 32'd0);
        check("rst_b", 32'(bus.o_b), 32'd0);
        check("rst_mask", 32'(bus.o_mask), 32'd0);
        check("rst_we", 32'(bus.o_we), 32'd0);
        check("rst_tag", 32'(bus.o_tag), 32'd0);
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) run_vec(i);

        run_stream();

        // Alternating valid: output gaps must mirror input gaps, two cycles later
        @(negedge clk);
        idle_inputs();
        for (int c = 0; c < 10; c++) begin
            load_px(c);
            bus.i_valid = (c < 6) && (c % 2 == 0);
            #1;
            check($sformatf("alt_valid_c%0d", c), 32'(bus.o_valid),
                  32'((c >= 2) && (c < 8) && (c % 2 == 0)));
            if ((c >= 2) && (c < 8) && (c % 2 == 0))
                check($sformatf("alt_tag_c%0d", c), 32'(bus.o_tag), 32'(c - 2));
            @(negedge clk);
        end
        bus.i_valid = 1'b0;

        // Reset while stalled with two tokens in flight
        @(negedge clk);
        bus.i_ready = 1'b0;
        load_px(7);
        bus.i_valid = 1'b1;
        @(negedge clk);
        load_px(9);
        @(negedge clk);
        bus.i_valid = 1'b0;
        check("rs_pre_valid", 32'(bus.o_valid), 32'd1);
        check("rs_pre_ready", 32'(bus.o_ready), 32'd0);
        check("rs_pre_r", 32'(bus.o_r), 32'd70);
        rst = 1'b1;
        @(negedge clk);
        check("rs_valid", 32'(bus.o_valid), 32'd0);
        check("rs_r", 32'(bus.o_r), 32'd0);
        check("rs_tag", 32'(bus.o_tag), 32'd0);
        check("rs_we", 32'(bus.o_we), 32'd0);
        rst = 1'b0;
        bus.i_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("rs_no_stale_c%0d", c), 32'(bus.o_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
